wb_board_mem_slave: RTL and testbench

- Wishbone classic slave that answers the board master's single read/write cycles on the 8-bit bus of the 16x16 board.
- Holds the 256-cell board state, 8 bits per cell, and sits on the slave side of the board bus.
- Contains a sweep engine that fills every cell with CLEAR_VAL after reset and on request. The bus stalls while the sweep runs.

---
 rtl/wb_board_mem_slave.sv | 166 ++++++++++++++++
 tb/tb_wb_board_mem_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_board_mem_slave.sv
// rtl/wb_board_mem_slave.sv - Wishbone classic slave holding the 16x16 board cell array with a clear sweep engine.
// Optional display read port enabled by BOARD_MEM_DISP_PORT_EN.
module wb_board_mem_slave #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL   = '0
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [ADDR_W-1:0] ADR_O,
  input  logic [DATA_W-1:0] DAT_O,
  input  logic              WE_O,
  input  logic              STB_O,
  input  logic              CYC_O,
  output logic [DATA_W-1:0] DAT_I,
  output logic              ACK_I,
  input  logic              clear_req,
  output logic              busy
`ifdef BOARD_MEM_DISP_PORT_EN
  ,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data
`endif
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_ACK} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                we_q, we_d;
  logic                pend_q, pend_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                commit;

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    pend_d    = pend_q;
    rdat_d    = rdat_q;
    mem_we    = 1'b0;
    mem_waddr = sweep_q;
    mem_wdata = CLEAR_VAL;
    commit    = 1'b0;

    case (state_q)
      S_CLEAR: begin
        mem_we  = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
        end else if (CYC_O && STB_O) begin
          adr_d = ADR_O;
          dat_d = DAT_O;
          we_d  = WE_O;
          if (WS == 4'd0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            cnt_d   = WS;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        pend_d = pend_q | clear_req;
        if (!CYC_O) begin
          // Aborted cycle: nothing committed, but a pending clear still runs.
          state_d = (pend_q | clear_req) ? S_CLEAR : S_IDLE;
          pend_d  = 1'b0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = (pend_q | clear_req) ? S_CLEAR : S_IDLE;
        pend_d  = 1'b0;
      end
    endcase

    // The access happens on the same edge that raises ACK_I.
    if (commit) begin
      if (we_d) begin
        mem_we    = 1'b1;
        mem_waddr = adr_d;
        mem_wdata = dat_d;
      end else begin
        rdat_d = mem[adr_d];
      end
    end

    ack_d  = (state_d == S_ACK);
    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_CLEAR;
      sweep_q <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign DAT_I = rdat_q;
  assign ACK_I = ack_q;
  assign busy  = busy_q;

`ifdef BOARD_MEM_DISP_PORT_EN
  logic [DATA_W-1:0] disp_data_q, disp_data_d;

  always_comb disp_data_d = mem[disp_addr];

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) disp_data_q <= '0;
    else        disp_data_q <= disp_data_d;
  end

  assign disp_data = disp_data_q;
`endif

endmodule

// File: tb/tb_wb_board_mem_slave.sv
// tb/tb_wb_board_mem_slave.sv - Bench for wb_board_mem_slave; instance 0 has no wait states, instance 1 has three.
module tb_wb_board_mem_slave;

  localparam int         N  = 2;
  localparam logic [7:0] CV = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adr [N];
  logic [7:0] wdat [N];
  logic [7:0] dat_i [N];
  logic       we [N];
  logic       stb [N];
  logic       cyc [N];
  logic       ack [N];
  logic       clr [N];
  logic       busy [N];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model: cycles of sweep left, pending transaction, expected outputs.
  int         m_sweep [N];
  bit         m_ack [N];
  bit         m_act [N];
  int         m_cnt [N];
  bit         m_pend [N];
  logic [7:0] m_adr [N];
  logic [7:0] m_dat [N];
  bit         m_we [N];
  logic [7:0] m_rd [N];
  logic [7:0] m_mem [N][256];

  always #5 clk = ~clk;

  wb_board_mem_slave #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0), .CLEAR_VAL(CV)) u_dut0 (
    .CLK_I(clk), .RST_I(rst_n), .ADR_O(adr[0]), .DAT_O(wdat[0]), .WE_O(we[0]),
    .STB_O(stb[0]), .CYC_O(cyc[0]), .DAT_I(dat_i[0]), .ACK_I(ack[0]),
    .clear_req(clr[0]), .busy(busy[0])
  );

  wb_board_mem_slave #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(3), .CLEAR_VAL(CV)) u_dut1 (
    .CLK_I(clk), .RST_I(rst_n), .ADR_O(adr[1]), .DAT_O(wdat[1]), .WE_O(we[1]),
    .STB_O(stb[1]), .CYC_O(cyc[1]), .DAT_I(dat_i[1]), .ACK_I(ack[1]),
    .clear_req(clr[1]), .busy(busy[1])
  );

  function automatic int ws_of(int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sweep[i] = 256;
      m_ack[i]   = 1'b0;
      m_act[i]   = 1'b0;
      m_cnt[i]   = 0;
      m_pend[i]  = 1'b0;
      m_rd[i]    = 8'h00;
    end
  endtask

  task automatic model_commit(input int i);
    if (m_we[i]) m_mem[i][m_adr[i]] = m_dat[i];
    else         m_rd[i] = m_mem[i][m_adr[i]];
    m_ack[i] = 1'b1;
    m_act[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    if (m_sweep[i] > 0) begin
      m_mem[i][256 - m_sweep[i]] = CV;
      m_sweep[i]--;
    end else if (m_ack[i]) begin
      m_ack[i] = 1'b0;
      if (m_pend[i] || clr[i]) m_sweep[i] = 256;
      m_pend[i] = 1'b0;
    end else if (m_act[i]) begin
      if (clr[i]) m_pend[i] = 1'b1;
      if (!cyc[i]) begin
        m_act[i] = 1'b0;
        if (m_pend[i]) m_sweep[i] = 256;
        m_pend[i] = 1'b0;
      end else begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) model_commit(i);
      end
    end else if (clr[i]) begin
      m_sweep[i] = 256;
    end else if (cyc[i] && stb[i]) begin
      m_adr[i] = adr[i];
      m_dat[i] = wdat[i];
      m_we[i]  = we[i];
      if (ws_of(i) == 0) begin
        model_commit(i);
      end else begin
        m_act[i] = 1'b1;
        m_cnt[i] = ws_of(i);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < N; i++) model_step(i);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < N; i++) begin
          check($sformatf("ack%0d", i), int'(ack[i]), int'(m_ack[i]));
          check($sformatf("dat%0d", i), int'(dat_i[i]), int'(m_rd[i]));
          check($sformatf("busy%0d", i), int'(busy[i]), (m_sweep[i] > 0) ? 1 : 0);
        end
      end
    end
  end

  task automatic run_txn(input int i, input logic [7:0] a, input logic [7:0] d, input bit w,
                         input bit scramble, input int abort_at, input int clr_at,
                         output bit got, output int lat, output bit busy_at_ack);
    got = 1'b0;
    lat = 0;
    busy_at_ack = 1'b0;
    @(posedge clk); #1;
    adr[i] = a; wdat[i] = d; we[i] = w; cyc[i] = 1'b1; stb[i] = 1'b1;
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      clr[i] = (n == clr_at);
      if (scramble) begin
        adr[i]  = 8'($urandom);
        wdat[i] = 8'($urandom);
        we[i]   = 1'($urandom);
      end
      if (n == abort_at) begin
        cyc[i] = 1'b0;
        stb[i] = 1'b0;
      end
      @(negedge clk);
      if (ack[i]) begin
        got = 1'b1;
        lat = n;
        busy_at_ack = busy[i];
        break;
      end
      if (n == abort_at) break;
    end
    @(posedge clk); #1;
    cyc[i] = 1'b0; stb[i] = 1'b0; clr[i] = 1'b0;
    if (!got && abort_at < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL txn_timeout%0d: no ACK within 800 cycles, required one", i);
    end
  endtask

  task automatic count_busy(input int i, output int c);
    c = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (!busy[i]) break;
      c++;
    end
  endtask

  task automatic pulse_clear(input int i);
    @(posedge clk); #1 clr[i] = 1'b1;
    @(posedge clk); #1 clr[i] = 1'b0;
  endtask

  task automatic quiet_acks(input int i, input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      seen += int'(ack[i]);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit         got;
    bit         bsy;
    int         lat;
    int         c;
    int         seen;
    logic [7:0] probe [3];

    for (int i = 0; i < N; i++) begin
      adr[i] = '0; wdat[i] = '0; we[i] = 1'b0; stb[i] = 1'b0; cyc[i] = 1'b0; clr[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack0", int'(ack[0]), 0);
    check("rst_dat0", int'(dat_i[0]), 0);
    check("rst_busy0", int'(busy[0]), 1);
    chk_en = 1'b1;

    @(posedge clk); #1 rst_n = 1'b1;
    count_busy(0, c);
    check("post_reset_busy_cycles", c, 256);
    check("busy1_after_sweep", int'(busy[1]), 0);

    probe[0] = 8'h00; probe[1] = 8'h7F; probe[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      run_txn(0, probe[k], 8'h00, 1'b0, 1'b0, -1, -1, got, lat, bsy);
      check($sformatf("swept_rd_%0h", probe[k]), int'(dat_i[0]), 0);
      check("swept_rd_lat", lat, 1);
    end

    run_txn(0, 8'h3C, 8'hA5, 1'b1, 1'b0, -1, -1, got, lat, bsy);
    check("ws0_wr_lat", lat, 1);
    run_txn(0, 8'h3C, 8'h00, 1'b0, 1'b0, -1, -1, got, lat, bsy);
    check("ws0_rd_lat", lat, 1);
    check("ws0_rd_3c", int'(dat_i[0]), 'hA5);

    run_txn(1, 8'h05, 8'h11, 1'b1, 1'b0, -1, -1, got, lat, bsy);
    check("ws3_wr_lat", lat, 4);
    run_txn(1, 8'h05, 8'h00, 1'b0, 1'b1, -1, -1, got, lat, bsy);
    check("ws3_rd_lat", lat, 4);
    check("ws3_rd_05", int'(dat_i[1]), 'h11);
    run_txn(1, 8'h00, 8'h11, 1'b1, 1'b0, 2, -1, got, lat, bsy);
    check("abort_got_ack", int'(got), 0);
    quiet_acks(1, 6, seen);
    check("abort_no_ack", seen, 0);
    run_txn(1, 8'h00, 8'h00, 1'b0, 1'b0, -1, -1, got, lat, bsy);
    check("abort_rd_00", int'(dat_i[1]), 0);

    run_txn(1, 8'h10, 8'h55, 1'b1, 1'b0, -1, 1, got, lat, bsy);
    check("clr_in_wait_ack", int'(got), 1);
    check("clr_in_wait_lat", lat, 4);
    count_busy(1, c);
    check("clr_in_wait_busy_cycles", c, 256);
    run_txn(1, 8'h10, 8'h00, 1'b0, 1'b0, -1, -1, got, lat, bsy);
    check("clr_in_wait_rd_10", int'(dat_i[1]), int'(CV));

    pulse_clear(0);
    repeat (3) @(posedge clk);
    run_txn(0, 8'h3C, 8'h00, 1'b0, 1'b0, -1, -1, got, lat, bsy);
    check("held_req_busy_at_ack", int'(bsy), 0);
    check("held_req_lat", lat, 253);
    check("held_req_rd_3c", int'(dat_i[0]), int'(CV));
    quiet_acks(0, 4, seen);
    check("held_req_single_ack", seen, 0);

    run_txn(0, 8'h20, 8'h5A, 1'b1, 1'b0, -1, -1, got, lat, bsy);
    run_txn(0, 8'h20, 8'h00, 1'b0, 1'b0, -1, -1, got, lat, bsy);
    check("rd_20", int'(dat_i[0]), 'h5A);

    pulse_clear(0);
    repeat (128) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midsweep_rst_ack0", int'(ack[0]), 0);
    check("midsweep_rst_dat0", int'(dat_i[0]), 0);
    check("midsweep_rst_busy0", int'(busy[0]), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy(0, c);
    check("midsweep_rst_busy_cycles", c, 256);

    for (int it = 0; it < 250; it++) begin
      int i;
      int ab;
      int ca;
      i  = int'($urandom_range(0, 1));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : -1;
      ca = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 4)) : -1;
      run_txn(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ab, ca, got, lat, bsy);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
